reg_file_nbits: RTL and testbench
=================================

REG_FILE_NBITS -- requirements
Module: reg_file_nbits

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (>=2, power of two).
REQ-003 SHALL derive localparam AW = clog2(DEPTH), the address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port waddr  input  AW  write address.
REQ-008 SHALL have port wdata  input  WIDTH  write data.
REQ-009 SHALL have port re_a  input  1  read enable, port A.
REQ-010 SHALL have port raddr_a  input  AW  read address, port A.
REQ-011 SHALL have port rdata_a  output  WIDTH  registered read data, port A.
REQ-012 SHALL have port re_b  input  1  read enable, port B.
REQ-013 SHALL have port raddr_b  input  AW  read address, port B.
REQ-014 SHALL have port rdata_b  output  WIDTH  registered read data, port B.
REQ-015 SHALL have port clr  input  1  one-cycle request to start a sequential clear of all entries.
REQ-016 SHALL have port busy  output  1  registered; high while a clear sweep is in progress.

Function
REQ-017 SHALL store DEPTH entries of WIDTH bits; write and both reads are independent and may occur in the same cycle.
REQ-018 SHALL write wdata into mem[waddr] at the rising edge when we=1, busy=0 and clr=0.
REQ-019 SHALL update rdata_x at the rising edge when re_x=1, with mem[raddr_x] (1-cycle latency); rdata_x SHALL hold its value when re_x=0.
REQ-020 SHALL bypass write-first: if an accepted write and re_x=1 hit the same address in one cycle, rdata_x SHALL receive wdata.
REQ-021 SHALL allow both read ports to address the same entry in one cycle; both return identical data.
REQ-022 SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR when clr=1; CLEAR -> IDLE after the entry at pointer DEPTH-1 is cleared.
REQ-023 SHALL, on IDLE -> CLEAR, load clear pointer 0; in CLEAR each edge sets mem[ptr] to 0 and increments ptr; busy SHALL be high for exactly DEPTH cycles, beginning the cycle after clr is sampled.
REQ-024 SHALL give clr priority over we in the same IDLE cycle: the write is dropped.
REQ-025 SHALL ignore we while busy=1 (no entry modified except by the sweep).
REQ-026 SHALL ignore clr while busy=1 (no restart, no extension).
REQ-027 SHALL, for re_x=1 while busy=1, load rdata_x with 0.
REQ-028 SHALL leave rdata_a/rdata_b unchanged by the sweep itself unless re_x is asserted.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force all entries, rdata_a, rdata_b and ptr to 0, busy to 0 and FSM to IDLE.
REQ-030 SHALL, on rst_n assertion mid-sweep, abort the sweep; first edge after release is in IDLE with all entries 0.
REQ-031 SHALL accept no write, read or clr at an edge where rst_n=0.

Verification (WIDTH=4, DEPTH=4)
REQ-032 Reset then re_a=1, raddr_a=2 -> rdata_a=0x0 after one edge; busy=0.
REQ-033 Write 0xA@1, 0x5@3; next cycle re_a raddr_a=1, re_b raddr_b=3 -> rdata_a=0xA, rdata_b=0x5 one edge later; re low next -> both hold.
REQ-034 Same cycle we waddr=2 wdata=0xC and re_a raddr_a=2 -> rdata_a=0xC after that edge (bypass).
REQ-035 Entries 0xF everywhere; pulse clr with we waddr=0 wdata=0x3 -> write dropped, busy high exactly 4 cycles, we during busy ignored, afterward all reads return 0x0; clr during busy does not extend busy.
REQ-036 Start sweep, assert rst_n=0 at 2nd busy cycle -> busy=0, rdata_a=rdata_b=0 immediately; after release all entries read 0x0 and a new write/read of 0x7 works.

Source files
------------

// File: rtl/reg_file_nbits.sv
// reg_file_nbits: DEPTH x WIDTH register file with one write port, two
// registered read ports and a sequential clear sweep.
//
// Ports
//   clk, rst_n         clock (rising edge), async active-low reset
//   we/waddr/wdata     write port; dropped while busy or when clr is high
//   re_a/raddr_a       read port A; rdata_a is registered, write-first bypass
//   re_b/raddr_b       read port B; same behaviour as port A
//   clr                one-cycle request to zero every entry, one per cycle
//   busy               high for exactly DEPTH cycles while the sweep runs

// One storage entry. The sweep clear and a normal write are never enabled
// together because writes are only accepted in IDLE.
module reg_file_entry #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             clr_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (clr_en) q <= '0;
    else if (wr_en)  q <= wdata;
  end
endmodule

module reg_file_nbits #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr,
  output logic             busy
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                         state, state_nx;
  logic   [AW-1:0]                ptr, ptr_nx;
  logic                           busy_nx;
  logic                           wr_acc;
  logic   [DEPTH-1:0][WIDTH-1:0]  mem;
  logic   [DEPTH-1:0]             wr_en, clr_en;

  // clr wins over we in the same IDLE cycle; nothing is written mid-sweep.
  assign wr_acc = we && (state == S_IDLE) && !clr;

  // Sweep control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      busy  <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      S_IDLE: begin
        if (clr) begin
          state_nx = S_CLEAR;
          ptr_nx   = '0;
        end
      end
      S_CLEAR: begin
        ptr_nx = ptr + AW'(1);
        if (ptr == AW'(DEPTH - 1)) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // busy mirrors the registered state so it is itself a flop output.
    busy_nx = (state_nx == S_CLEAR);
  end

  // Storage
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign wr_en[i]  = wr_acc && (waddr == AW'(i));
    assign clr_en[i] = (state == S_CLEAR) && (ptr == AW'(i));
    reg_file_entry #(.WIDTH(WIDTH)) u_ent (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en[i]),
      .clr_en (clr_en[i]),
      .wdata  (wdata),
      .q      (mem[i])
    );
  end

  // Registered reads: zero while sweeping, write-first bypass otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) begin
        if (state == S_CLEAR)                  rdata_a <= '0;
        else if (wr_acc && waddr == raddr_a)   rdata_a <= wdata;
        else                                   rdata_a <= mem[raddr_a];
      end
      if (re_b) begin
        if (state == S_CLEAR)                  rdata_b <= '0;
        else if (wr_acc && waddr == raddr_b)   rdata_b <= wdata;
        else                                   rdata_b <= mem[raddr_b];
      end
    end
  end
endmodule

// File: tb/tb_reg_file_nbits.sv
module tb_reg_file_nbits;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             we, re_a, re_b, clr;
  logic [AW-1:0]    waddr, raddr_a, raddr_b;
  logic [WIDTH-1:0] wdata, rdata_a, rdata_b;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Reference model: plain array + "cycles of sweep left" counter.
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [WIDTH-1:0] m_ra, m_rb;
  int               m_left;

  reg_file_nbits #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .clr(clr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ra   = '0;
    m_rb   = '0;
    m_left = 0;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, sample #1 later.
  task automatic step(input logic t_we, input logic [AW-1:0] t_wa,
                      input logic [WIDTH-1:0] t_wd,
                      input logic t_rea, input logic [AW-1:0] t_ra,
                      input logic t_reb, input logic [AW-1:0] t_rb,
                      input logic t_clr);
    logic bsy, wok;
    we = t_we; waddr = t_wa; wdata = t_wd;
    re_a = t_rea; raddr_a = t_ra; re_b = t_reb; raddr_b = t_rb; clr = t_clr;
    @(posedge clk);
    if (rst_n) begin
      bsy = (m_left > 0);
      wok = t_we && !bsy && !t_clr;
      if (t_rea) m_ra = bsy ? '0 : ((wok && t_wa == t_ra) ? t_wd : m_mem[t_ra]);
      if (t_reb) m_rb = bsy ? '0 : ((wok && t_wa == t_rb) ? t_wd : m_mem[t_rb]);
      if (bsy) begin
        m_mem[DEPTH - m_left] = '0;
        m_left--;
      end else if (t_clr) begin
        m_left = DEPTH;
      end
      if (wok) m_mem[t_wa] = t_wd;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    we = 0; waddr = 0; wdata = 0; re_a = 0; raddr_a = 0;
    re_b = 0; raddr_b = 0; clr = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rdata_a !== 4'h0) begin errors++; $display("FAIL reset_rdata_a got=%h exp=0", rdata_a); end
    checks++; if (rdata_b !== 4'h0) begin errors++; $display("FAIL reset_rdata_b got=%h exp=0", rdata_b); end
    // Edge while in reset: write, read and clr must all be ignored.
    step(1, 2, 4'h5, 1, 2, 1, 2, 1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inreset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 2, 0, 0, 0);
    checks++; if (rdata_a !== 4'h0) begin errors++; $display("FAIL reset_read2 got=%h exp=0", rdata_a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy2 got=%b exp=0", busy); end
  endtask

  task automatic test_write_read();
    step(1, 1, 4'hA, 0, 0, 0, 0, 0);
    step(1, 3, 4'h5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 3, 0);
    checks++; if (rdata_a !== 4'hA) begin errors++; $display("FAIL wr_rd_a got=%h exp=a", rdata_a); end
    checks++; if (rdata_b !== 4'h5) begin errors++; $display("FAIL wr_rd_b got=%h exp=5", rdata_b); end
    // Read enables low, but addresses move: outputs must hold.
    step(1, 1, 4'h2, 0, 0, 0, 0, 0);
    checks++; if (rdata_a !== 4'hA) begin errors++; $display("FAIL hold_a got=%h exp=a", rdata_a); end
    checks++; if (rdata_b !== 4'h5) begin errors++; $display("FAIL hold_b got=%h exp=5", rdata_b); end
    // Both ports on one entry.
    step(0, 0, 0, 1, 1, 1, 1, 0);
    checks++; if (rdata_a !== 4'h2 || rdata_b !== 4'h2) begin
      errors++; $display("FAIL same_addr got=%h/%h exp=2/2", rdata_a, rdata_b); end
  endtask

  task automatic test_bypass();
    step(1, 2, 4'hC, 1, 2, 1, 0, 0);
    checks++; if (rdata_a !== 4'hC) begin errors++; $display("FAIL bypass_a got=%h exp=c", rdata_a); end
    checks++; if (rdata_b !== m_rb) begin errors++; $display("FAIL bypass_b_other got=%h exp=%h", rdata_b, m_rb); end
  endtask

  task automatic test_clear();
    int nbusy;
    for (int i = 0; i < DEPTH; i++) step(1, AW'(i), 4'hF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2, 0);
    checks++; if (rdata_b !== 4'hF) begin errors++; $display("FAIL pre_clear_b got=%h exp=f", rdata_b); end
    // clr with a competing write to entry 0.
    step(1, 0, 4'h3, 0, 0, 0, 0, 1);
    nbusy = busy ? 1 : 0;
    for (int k = 0; k < DEPTH; k++) begin
      // Writes every busy cycle, a second clr, one read on port A.
      step(1, AW'(k), 4'h9, (k == 1), 1, 0, 0, (k == 0));
      if (k == 1) begin
        checks++; if (rdata_a !== 4'h0) begin errors++; $display("FAIL read_busy got=%h exp=0", rdata_a); end
      end
      if (busy) nbusy++;
    end
    checks++; if (nbusy !== DEPTH) begin errors++; $display("FAIL busy_len got=%0d exp=%0d", nbusy, DEPTH); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end got=%b exp=0", busy); end
    checks++; if (rdata_b !== 4'hF) begin errors++; $display("FAIL sweep_keeps_b got=%h exp=f", rdata_b); end
    for (int i = 0; i < DEPTH; i += 2) begin
      step(0, 0, 0, 1, AW'(i), 1, AW'(i + 1), 0);
      checks++; if (rdata_a !== 4'h0 || rdata_b !== 4'h0) begin
        errors++; $display("FAIL after_clear[%0d] got=%h/%h exp=0/0", i, rdata_a, rdata_b); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < DEPTH; i++) step(1, AW'(i), 4'h6, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (rdata_a !== 4'h0 || rdata_b !== 4'h0) begin
      errors++; $display("FAIL abort_rdata got=%h/%h exp=0/0", rdata_a, rdata_b); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
    for (int i = 0; i < DEPTH; i += 2) begin
      step(0, 0, 0, 1, AW'(i), 1, AW'(i + 1), 0);
      checks++; if (rdata_a !== 4'h0 || rdata_b !== 4'h0) begin
        errors++; $display("FAIL post_rst[%0d] got=%h/%h exp=0/0", i, rdata_a, rdata_b); end
    end
    step(1, 1, 4'h7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    checks++; if (rdata_a !== 4'h7) begin errors++; $display("FAIL post_rst_wr got=%h exp=7", rdata_a); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1), AW'($urandom), WIDTH'($urandom),
           $urandom_range(0, 1), AW'($urandom),
           $urandom_range(0, 1), AW'($urandom),
           ($urandom_range(0, 19) == 0));
      checks++; if (rdata_a !== m_ra) begin errors++; $display("FAIL rnd_a n=%0d got=%h exp=%h", n, rdata_a, m_ra); end
      checks++; if (rdata_b !== m_rb) begin errors++; $display("FAIL rnd_b n=%0d got=%h exp=%h", n, rdata_b, m_rb); end
      checks++; if (busy !== (m_left > 0)) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, m_left > 0); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
